signal_selector: RTL and testbench
==================================

# signal_selector

Registered N:1 signal selector with handshaked channel-select requests. Switchover happens only on an external sync strobe, and an optional linear crossfade can be compiled in. It sits in the DAC/ADC datapath where a 2:1 bypass multiplexer would otherwise sit. Switching between sources, for example waveform versus bypass or sequence slots, is aligned to a period boundary so it causes no step discontinuity.

## Interface
Parameters:
- DATA_WIDTH, 16, width of each signed sample.
- NUM_INPUTS, 4, number of input channels (2..16).
- SEL_WIDTH, 2, select width; must be at least clog2(NUM_INPUTS).
- FADE_LEN_LOG2, 4, crossfade length is L = 2^FADE_LEN_LOG2 cycles (1..8); used only with crossfade compiled in.

Ports:
- clk, in, 1, clock.
- aresetn, in, 1, reset, synchronous, active-low.
- insignals, in, NUM_INPUTS*DATA_WIDTH, packed inputs; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- sel_req, in, SEL_WIDTH, requested channel.
- sel_valid, in, 1, request valid.
- sel_ready, out, 1, request can be accepted.
- sync, in, 1, switchover strobe (period boundary).
- outsignal, out, DATA_WIDTH, registered selected sample.
- active_sel, out, SEL_WIDTH, channel currently driving the output.
- switching, out, 1, high while a switch is pending or fading.
- sel_err, out, 1, one-cycle pulse when an out-of-range request is dropped.

## Operation
- Reset values: outsignal 0, active_sel 0, sel_ready 0, switching 0, sel_err 0, state IDLE, fade counter 0.
- sel_ready is registered. It rises on the first edge after aresetn is released and is 1 only in IDLE.
- Handshake: a request is accepted on an edge where sel_valid && sel_ready. sel_req is captured into target_sel.
- IDLE: outsignal <= channel[active_sel] on every edge. sync is ignored.
- Accepted request, out-of-range (sel_req >= NUM_INPUTS): dropped, sel_err pulses for 1 cycle, stays in IDLE.
- Accepted request equal to active_sel: completes immediately, stays in IDLE, sel_ready stays 1, no sync needed.
- Accepted request otherwise: state goes to PENDING, sel_ready goes to 0, switching goes to 1.
- PENDING: output continues from active_sel. Edge with sync=1:
  - Without crossfade: active_sel <= target_sel, state goes to IDLE, sel_ready goes to 1, switching goes to 0.
  - With crossfade: state goes to FADE and the fade counter c is set to 0.
- FADE, each edge: w = c+1 and outsignal <= (old*(L-w) + new*w) >>> FADE_LEN_LOG2, then c increments.
  - old = channel[active_sel], new = channel[target_sel].
  - When w == L: active_sel <= target_sel, state goes to IDLE, sel_ready goes to 1, switching goes to 0.
  - sync and sel_valid are ignored during FADE.
- Arithmetic: signed. Weights are unsigned with FADE_LEN_LOG2+1 bits. The sum is DATA_WIDTH+FADE_LEN_LOG2+1 bits signed. The arithmetic right shift floors the result. The result always fits DATA_WIDTH, so no saturation is needed.
- Reset mid-PENDING or mid-FADE aborts the switch and forces all reset values.

## Timing
- Data latency is 1 cycle: an input sample at edge t appears on outsignal after edge t.
- Without crossfade, the first new-channel sample appears 1 edge after the sync edge.
- With crossfade:
  - The fade occupies exactly L edges starting at the sync edge+1.
  - The last fade edge outputs new exactly.
  - sel_ready is 1 from the edge after that.
- A sync on the same edge a request is accepted does not trigger the switch. The switch requires a later sync.

## Configuration
- SIGNAL_SELECTOR_CROSSFADE_EN defined: FADE state, multipliers and fade counter are built. Behaviour is as in Operation.
- Not defined: no multipliers. The switch is a hard cut at sync. FADE_LEN_LOG2 is unused.

## Test plan
- Reset, then release; all inputs constant (ch0=100, ch1=-200): outsignal=0 during reset, 100 one edge after release; sel_ready=1 on the first edge after release.
- Request ch1, then sync 5 cycles later, crossfade off: switching=1 for those cycles with output 100; outsignal=-200 one edge after sync; active_sel=1.
- Crossfade on, L=4, ch0=0, ch1=1000: outputs after sync are 250, 500, 750, 1000; sel_ready=1 on the next edge.
- Request sel_req=5 with NUM_INPUTS=4: sel_err pulses once, active_sel unchanged, sel_ready stays 1.
- Request equal to active_sel: no PENDING state, switching stays 0, sel_ready stays 1.
- aresetn low during the 2nd fade cycle: outsignal=0, active_sel=0, switching=0; normal operation resumes after release.

Source files
------------

// File: rtl/signal_selector.sv
// -----------------------------------------------------------------------------
// signal_selector
//
// Registered N:1 sample selector for the DAC/ADC datapath. A new source is
// requested through a valid/ready handshake, but the output only moves to it on
// an external sync strobe (a waveform period boundary), so switching between
// sources never produces a step in the middle of a period.
//
// Build option:
//   SIGNAL_SELECTOR_CROSSFADE_EN  - when defined, the switch is a linear
//                                   crossfade of L = 2^FADE_LEN_LOG2 cycles
//                                   starting on the cycle after sync. When
//                                   undefined, the switch is a hard cut at sync
//                                   and FADE_LEN_LOG2 is unused.
//
// Ports:
//   clk         in   clock
//   aresetn     in   synchronous active-low reset
//   insignals   in   packed channels, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sel_req     in   requested channel
//   sel_valid   in   request valid
//   sel_ready   out  request can be accepted (registered, high only in IDLE)
//   sync        in   switchover strobe
//   outsignal   out  registered selected (or blended) sample
//   active_sel  out  channel currently driving the output
//   switching   out  high while a switch is pending or fading
//   sel_err     out  one-cycle pulse when an out-of-range request is dropped
// -----------------------------------------------------------------------------
module signal_selector #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_INPUTS    = 4,
    parameter int SEL_WIDTH     = 2,
    parameter int FADE_LEN_LOG2 = 4
) (
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] insignals,
    input  logic [SEL_WIDTH-1:0]             sel_req,
    input  logic                             sel_valid,
    output logic                             sel_ready,
    input  logic                             sync,
    output logic signed [DATA_WIDTH-1:0]     outsignal,
    output logic [SEL_WIDTH-1:0]             active_sel,
    output logic                             switching,
    output logic                             sel_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1
`ifdef SIGNAL_SELECTOR_CROSSFADE_EN
        ,
        ST_FADE    = 2'd2
`endif
    } state_t;

    // Plain mux over the packed input bus; an unmatched select yields zero.
    function automatic logic signed [DATA_WIDTH-1:0] pick_channel(
        input logic [NUM_INPUTS*DATA_WIDTH-1:0] bus,
        input logic [SEL_WIDTH-1:0]             sel
    );
        logic signed [DATA_WIDTH-1:0] r;
        r = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (int'(sel) == i) begin
                r = bus[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_t                        state_q, state_d;
    logic [SEL_WIDTH-1:0]          active_sel_q, active_sel_d;
    logic [SEL_WIDTH-1:0]          target_sel_q, target_sel_d;
    logic signed [DATA_WIDTH-1:0]  outsignal_q, outsignal_d;
    logic                          sel_ready_q, sel_ready_d;
    logic                          switching_q, switching_d;
    logic                          sel_err_q, sel_err_d;

    logic                          accept_s;
    logic                          req_out_of_range_s;
    logic signed [DATA_WIDTH-1:0]  old_s;

    assign accept_s           = sel_valid && sel_ready_q;
    assign req_out_of_range_s = (int'(sel_req) >= NUM_INPUTS);
    assign old_s              = pick_channel(insignals, active_sel_q);

`ifdef SIGNAL_SELECTOR_CROSSFADE_EN
    localparam int W_W   = FADE_LEN_LOG2 + 1;
    localparam int SUM_W = DATA_WIDTH + FADE_LEN_LOG2 + 1;
    localparam logic [W_W-1:0] FADE_L = {1'b1, {FADE_LEN_LOG2{1'b0}}};

    logic [FADE_LEN_LOG2-1:0]     fade_cnt_q, fade_cnt_d;
    logic signed [DATA_WIDTH-1:0] new_s;
    logic [W_W-1:0]               w_new_s, w_old_s;
    logic signed [SUM_W-1:0]      old_ext_s, new_ext_s;
    logic signed [SUM_W-1:0]      w_old_ext_s, w_new_ext_s;
    logic signed [SUM_W-1:0]      sum_s;
    logic signed [DATA_WIDTH-1:0] fade_out_s;

    assign new_s = pick_channel(insignals, target_sel_q);

    // Linear blend: (old*(L-w) + new*w) >>> log2(L), with w = c+1.
    // Weights are zero-extended so they act as non-negative signed factors;
    // the shifted result is a convex combination and always fits DATA_WIDTH.
    always_comb begin
        w_new_s     = {1'b0, fade_cnt_q} + {{FADE_LEN_LOG2{1'b0}}, 1'b1};
        w_old_s     = FADE_L - w_new_s;
        old_ext_s   = {{W_W{old_s[DATA_WIDTH-1]}}, old_s};
        new_ext_s   = {{W_W{new_s[DATA_WIDTH-1]}}, new_s};
        w_old_ext_s = {{DATA_WIDTH{1'b0}}, w_old_s};
        w_new_ext_s = {{DATA_WIDTH{1'b0}}, w_new_s};
        sum_s       = (old_ext_s * w_old_ext_s) + (new_ext_s * w_new_ext_s);
        fade_out_s  = DATA_WIDTH'(sum_s >>> FADE_LEN_LOG2);
    end
`endif

    // Next-state and next-output logic for the switch controller.
    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        target_sel_d = target_sel_q;
        outsignal_d  = old_s;
        sel_err_d    = 1'b0;
`ifdef SIGNAL_SELECTOR_CROSSFADE_EN
        fade_cnt_d   = fade_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // sync is deliberately ignored here; only a pending switch uses it.
                if (accept_s) begin
                    if (req_out_of_range_s) begin
                        sel_err_d = 1'b1;
                    end else if (sel_req == active_sel_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        target_sel_d = sel_req;
                        state_d      = ST_PENDING;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (sync) begin
`ifdef SIGNAL_SELECTOR_CROSSFADE_EN
                    state_d    = ST_FADE;
                    fade_cnt_d = {FADE_LEN_LOG2{1'b0}};
`else
                    // Output on this edge is still the old channel; the new
                    // channel shows up on the next edge.
                    active_sel_d = target_sel_q;
                    state_d      = ST_IDLE;
`endif
                end else begin
                    state_d = ST_PENDING;
                end
            end
`ifdef SIGNAL_SELECTOR_CROSSFADE_EN
            ST_FADE: begin
                outsignal_d = fade_out_s;
                fade_cnt_d  = fade_cnt_q + {{(FADE_LEN_LOG2-1){1'b0}}, 1'b1};
                // Final step has full weight on the new channel, so handing
                // over active_sel here is seamless.
                if (w_new_s == FADE_L) begin
                    active_sel_d = target_sel_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_FADE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        sel_ready_d = (state_d == ST_IDLE);
        switching_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; synchronous reset aborts any switch.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            active_sel_q <= {SEL_WIDTH{1'b0}};
            target_sel_q <= {SEL_WIDTH{1'b0}};
            outsignal_q  <= {DATA_WIDTH{1'b0}};
            sel_ready_q  <= 1'b0;
            switching_q  <= 1'b0;
            sel_err_q    <= 1'b0;
`ifdef SIGNAL_SELECTOR_CROSSFADE_EN
            fade_cnt_q   <= {FADE_LEN_LOG2{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            target_sel_q <= target_sel_d;
            outsignal_q  <= outsignal_d;
            sel_ready_q  <= sel_ready_d;
            switching_q  <= switching_d;
            sel_err_q    <= sel_err_d;
`ifdef SIGNAL_SELECTOR_CROSSFADE_EN
            fade_cnt_q   <= fade_cnt_d;
`endif
        end
    end

    assign outsignal  = outsignal_q;
    assign active_sel = active_sel_q;
    assign sel_ready  = sel_ready_q;
    assign switching  = switching_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_signal_selector.sv
// -----------------------------------------------------------------------------
// tb_signal_selector
//
// Self-checking bench for signal_selector (NUM_INPUTS=4, SEL_WIDTH=3 so that
// out-of-range requests can be expressed, FADE_LEN_LOG2=2 i.e. L=4). Expected
// output samples are queued as each cycle's stimulus is applied and popped
// when the registered output is sampled after the edge. Expectations follow
// the build option SIGNAL_SELECTOR_CROSSFADE_EN.
// -----------------------------------------------------------------------------
module tb_signal_selector;

    localparam int DW = 16;
    localparam int NI = 4;
    localparam int SW = 3;
    localparam int FL = 2;

    logic                  clk;
    logic                  aresetn;
    logic [NI*DW-1:0]      insignals;
    logic [SW-1:0]         sel_req;
    logic                  sel_valid;
    logic                  sel_ready;
    logic                  sync;
    logic signed [DW-1:0]  outsignal;
    logic [SW-1:0]         active_sel;
    logic                  switching;
    logic                  sel_err;

    logic signed [DW-1:0]  ch_val [NI];

    int err_cnt;
    int chk_cnt;
    int exp_q[$];

    assign insignals = {ch_val[3], ch_val[2], ch_val[1], ch_val[0]};

    signal_selector #(
        .DATA_WIDTH   (DW),
        .NUM_INPUTS   (NI),
        .SEL_WIDTH    (SW),
        .FADE_LEN_LOG2(FL)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .insignals  (insignals),
        .sel_req    (sel_req),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .sync       (sync),
        .outsignal  (outsignal),
        .active_sel (active_sel),
        .switching  (switching),
        .sel_err    (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: queue the expected output for the current stimulus, then
    // compare it against the registered output sampled after the edge.
    task automatic tick(input int exp_out);
        int e;
        exp_q.push_back(exp_out);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_value("outsignal", int'(outsignal), e);
    endtask

    // Apply sync on a pending switch and walk through the changeover.
    // o_old: output on the sync edge; e1..e3: fade steps; e_new: new channel.
    task automatic do_sync(input int o_old, input int e1, input int e2,
                           input int e3, input int e_new);
        sync = 1'b1;
        tick(o_old);
        sync = 1'b0;
`ifdef SIGNAL_SELECTOR_CROSSFADE_EN
        check_value("fade_switching", int'(switching), 1);
        check_value("fade_ready", int'(sel_ready), 0);
        tick(e1);
        check_value("fade1_ready", int'(sel_ready), 0);
        tick(e2);
        tick(e3);
        check_value("fade3_switching", int'(switching), 1);
        tick(e_new);
`else
        check_value("cut_switching", int'(switching), 0);
        check_value("cut_ready", int'(sel_ready), 1);
        tick(e_new);
`endif
        check_value("done_switching", int'(switching), 0);
        check_value("done_ready", int'(sel_ready), 1);
    endtask

    initial begin
        err_cnt   = 0;
        chk_cnt   = 0;
        aresetn   = 1'b0;
        sel_req   = 3'd0;
        sel_valid = 1'b0;
        sync      = 1'b0;
        ch_val[0] = 16'sd100;
        ch_val[1] = -16'sd200;
        ch_val[2] = -16'sd2;
        ch_val[3] = 16'sd1;

        // Reset state.
        for (int i = 0; i < 3; i++) begin
            tick(0);
            check_value("rst_ready", int'(sel_ready), 0);
            check_value("rst_active", int'(active_sel), 0);
            check_value("rst_switching", int'(switching), 0);
            check_value("rst_err", int'(sel_err), 0);
        end

        // Release: channel 0 flows, ready rises on the first edge.
        aresetn = 1'b1;
        tick(100);
        check_value("rel_ready", int'(sel_ready), 1);
        check_value("rel_switching", int'(switching), 0);

        // sync while idle changes nothing.
        sync = 1'b1;
        tick(100);
        sync = 1'b0;
        check_value("idle_sync_active", int'(active_sel), 0);

        // Request ch1; output holds ch0 while pending.
        sel_req   = 3'd1;
        sel_valid = 1'b1;
        tick(100);
        sel_valid = 1'b0;
        check_value("req1_switching", int'(switching), 1);
        check_value("req1_ready", int'(sel_ready), 0);
        for (int i = 0; i < 4; i++) begin
            tick(100);
            check_value("pend_switching", int'(switching), 1);
        end
        do_sync(100, 25, -50, -125, -200);
        check_value("sw1_active", int'(active_sel), 1);

        // Out-of-range request is dropped with a single error pulse.
        sel_req   = 3'd5;
        sel_valid = 1'b1;
        tick(-200);
        sel_valid = 1'b0;
        check_value("oor_err", int'(sel_err), 1);
        check_value("oor_active", int'(active_sel), 1);
        check_value("oor_ready", int'(sel_ready), 1);
        check_value("oor_switching", int'(switching), 0);
        tick(-200);
        check_value("oor_err_clear", int'(sel_err), 0);

        // Request equal to active channel completes at once.
        sel_req   = 3'd1;
        sel_valid = 1'b1;
        tick(-200);
        sel_valid = 1'b0;
        check_value("same_switching", int'(switching), 0);
        check_value("same_ready", int'(sel_ready), 1);
        check_value("same_err", int'(sel_err), 0);
        tick(-200);
        check_value("same_switching2", int'(switching), 0);

        // 1 -> 3 with ch1=0, ch3=1000.
        ch_val[1] = 16'sd0;
        ch_val[3] = 16'sd1000;
        tick(0);
        sel_req   = 3'd3;
        sel_valid = 1'b1;
        tick(0);
        sel_valid = 1'b0;
        tick(0);
        do_sync(0, 250, 500, 750, 1000);
        check_value("sw3_active", int'(active_sel), 3);
        tick(1000);
        check_value("sw3_ready_next", int'(sel_ready), 1);

        // 3 -> 2; sync on the accepting edge must not start the switch.
        // Values chosen so the fade exercises floor rounding on negatives.
        ch_val[3] = 16'sd1;
        tick(1);
        sel_req   = 3'd2;
        sel_valid = 1'b1;
        sync      = 1'b1;
        tick(1);
        sel_valid = 1'b0;
        sync      = 1'b0;
        check_value("samesync_switching", int'(switching), 1);
        check_value("samesync_active", int'(active_sel), 3);
        tick(1);
        check_value("samesync_pending", int'(switching), 1);
        do_sync(1, 0, -1, -2, -2);
        check_value("sw2_active", int'(active_sel), 2);

        // Reset in the middle of a switch aborts it.
        sel_req   = 3'd0;
        sel_valid = 1'b1;
        tick(-2);
        sel_valid = 1'b0;
`ifdef SIGNAL_SELECTOR_CROSSFADE_EN
        sync = 1'b1;
        tick(-2);
        sync = 1'b0;
        tick(23);
`endif
        aresetn = 1'b0;
        tick(0);
        check_value("abort_active", int'(active_sel), 0);
        check_value("abort_switching", int'(switching), 0);
        check_value("abort_ready", int'(sel_ready), 0);
        aresetn = 1'b1;
        tick(100);
        check_value("resume_ready", int'(sel_ready), 1);

        // Normal switching after reset: 0 -> 1 (ch0=100, ch1=0).
        sel_req   = 3'd1;
        sel_valid = 1'b1;
        tick(100);
        sel_valid = 1'b0;
        check_value("resume_switching", int'(switching), 1);
        do_sync(100, 75, 50, 25, 0);
        check_value("resume_active", int'(active_sel), 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
